// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU memory-port arbiter: FSM states, requester ids, default widths.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_e;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for one memory access: counts enabled cycles and flags the TIMEOUT-th one.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != CW'(TIMEOUT)))
            cnt_d = cnt_q + 1'b1;
    end

    // Fires during the last allowed cycle so the abort lands exactly TIMEOUT cycles after mem_req rose.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (DM),
// with DM priority, IF anti-starvation and an access watchdog.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ready,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_e    state_q, state_d;
    req_id_e       winner_q, winner_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_ready_q, if_ready_d, if_err_q, if_err_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          dm_ready_q, dm_ready_d, dm_err_q, dm_err_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;

    logic          tmo_clr, tmo_en, tmo_expired;
    logic          pick_if, acc_err;
    logic [DW-1:0] acc_rdata;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_ready_d  = 1'b0;
        dm_err_d    = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;
        // IF wins when DM is idle, or when DM has hogged STARVE_MAX grants in a row.
        pick_if     = if_req && (!dm_req || (streak_q == SW'(STARVE_MAX)));
        acc_err     = !mem_ack;
        acc_rdata   = (mem_ack && !mem_we_q) ? mem_rdata : '0;

        case (state_q)
            ST_IDLE: begin
                tmo_clr = 1'b1;
                if (if_req || dm_req) begin
                    state_d   = ST_GRANT;
                    mem_req_d = 1'b1;
                    if (pick_if) begin
                        winner_d    = REQ_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end else begin
                        winner_d    = REQ_DM;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        if (if_req && (streak_q != SW'(STARVE_MAX)))
                            streak_d = streak_q + 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                tmo_en = 1'b1;
                if (mem_ack || tmo_expired) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    if (winner_q == REQ_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = acc_rdata;
                        if_err_d   = acc_err;
                    end else begin
                        dm_ready_d = 1'b1;
                        dm_rdata_d = acc_rdata;
                        dm_err_d   = acc_err;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            winner_q    <= REQ_IF;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_ready_q  <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_ready_q  <= dm_ready_d;
            dm_err_q    <= dm_err_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign dm_ready  = dm_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_err    = dm_err_q;

endmodule
